// File: rtl/trap_pkg.sv
// Shared definitions for the trapezoidal-filter delay-line scheduler:
// state encoding, default geometry and a wrap-around pointer subtract.
package trap_pkg;

  localparam int TRAP_ADDR_W      = 9;
  localparam int TRAP_DEFAULT_DLY = 372;

  // Widest address the pointer helper supports.
  localparam int PTR_MAX_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_PRIME = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  // Modular subtract; callers keep only their low ADDR_W bits, which
  // gives the natural mod-2^ADDR_W wrap.
  function automatic logic [PTR_MAX_W-1:0] ptr_sub(
    input logic [PTR_MAX_W-1:0] a,
    input logic [PTR_MAX_W-1:0] b
  );
    return a - b;
  endfunction

endpackage

// File: rtl/trap_dly_sched_if.sv
// RAM-side bus of the delay scheduler: write/read addressing plus the
// delayed-sample qualifier that travels with the RAM read data.
interface trap_dly_sched_if #(
  parameter int ADDR_W = 9
) ();
  logic              ram_we;
  logic              ram_wzero;
  logic [ADDR_W-1:0] ram_waddr;
  logic [ADDR_W-1:0] ram_raddr;
  logic              dly_valid;

  modport master (
    output ram_we, ram_wzero, ram_waddr, ram_raddr, dly_valid
  );

  modport slave (
    input ram_we, ram_wzero, ram_waddr, ram_raddr, dly_valid
  );
endinterface

// File: rtl/trap_dly_ptr.sv
// Pointer block: circular write pointer, history fill counter, clear-sweep
// counter and read-address generation for the delay RAM.
module trap_dly_ptr
  import trap_pkg::*;
#(
  parameter int ADDR_W = TRAP_ADDR_W
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              sweep_start,
  input  logic              sweep_step,
  input  logic              hist_clear,
  input  logic              strobe_adv,
  input  logic              fill_inc,
  input  logic [ADDR_W-1:0] active_dly,
  output logic [ADDR_W-1:0] wp,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] sweep_addr,
  output logic              sweep_done,
  output logic              fill_hit
);

  logic [ADDR_W-1:0] wp_reg;
  logic [ADDR_W-1:0] fill_reg;
  // One extra bit so the sweep can tell "all 2^ADDR_W addresses issued".
  logic [ADDR_W:0]   sweep_reg;

  // Sweep counter holds the next clear address; write pointer and fill
  // restart together when a sweep completes.
  always_ff @(posedge clk) begin
    if (srst) begin
      wp_reg    <= '0;
      fill_reg  <= '0;
      sweep_reg <= '0;
    end else begin
      // Address 0 is issued by the top on the start edge itself.
      if (sweep_start) begin
        sweep_reg <= (ADDR_W+1)'(1);
      end else if (sweep_step) begin
        sweep_reg <= sweep_reg + 1'b1;
      end

      if (hist_clear) begin
        wp_reg   <= '0;
        fill_reg <= '0;
      end else if (strobe_adv) begin
        wp_reg <= wp_reg + 1'b1;
        if (fill_inc) begin
          fill_reg <= fill_reg + 1'b1;
        end
      end
    end
  end

  assign wp         = wp_reg;
  assign rd_addr    = ADDR_W'(ptr_sub(PTR_MAX_W'(wp_reg), PTR_MAX_W'(active_dly)));
  assign sweep_addr = sweep_reg[ADDR_W-1:0];
  assign sweep_done = sweep_reg[ADDR_W];
  assign fill_hit   = (fill_reg == active_dly);

endmodule

// File: rtl/trap_dly_sched.sv
// Delay-RAM scheduler for the trapezoidal comb stage x[n] - x[n-k]:
// clears the RAM, primes k samples of history, then flags every delayed
// read as genuine. All outputs are registered.
module trap_dly_sched
  import trap_pkg::*;
#(
  parameter int ADDR_W      = TRAP_ADDR_W,
  parameter int DEFAULT_DLY = TRAP_DEFAULT_DLY
) (
  input  logic              SYS_CLK,
  input  logic              RESET,
  input  logic              ENABLE,
  input  logic              CFG_WE,
  input  logic [ADDR_W-1:0] CFG_DLY,
  input  logic              SAMPLE_STB,
  trap_dly_sched_if.master  ram,
  output logic              BUSY,
  output logic              DROP,
  output logic              CFG_ERR,
  output logic [1:0]        STATE,
  output logic [ADDR_W-1:0] ACTIVE_DLY
);

  state_t            state_reg;
  logic [ADDR_W-1:0] active_dly_reg;
  logic [ADDR_W-1:0] pending_dly_reg;
  logic              ram_we_reg;
  logic              ram_wzero_reg;
  logic [ADDR_W-1:0] ram_waddr_reg;
  logic [ADDR_W-1:0] ram_raddr_reg;
  logic              valid_pend_reg;
  logic              dly_valid_reg;
  logic              busy_reg;
  logic              drop_reg;
  logic              cfg_err_reg;

  logic              cfg_ok;
  logic              run_ok;
  logic              sweep_start;
  logic              sweep_step;
  logic              hist_clear;
  logic              strobe_adv;
  logic              fill_inc;
  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] sweep_addr;
  logic              sweep_done;
  logic              fill_hit;

  // Pointer-block controls, mirroring the FSM branch priority below:
  // ENABLE low, then a valid config, then per-state behaviour.
  always_comb begin
    cfg_ok      = CFG_WE && (CFG_DLY != '0);
    run_ok      = ENABLE && !cfg_ok;
    sweep_start = ENABLE && (cfg_ok || (state_reg == ST_IDLE));
    sweep_step  = run_ok && (state_reg == ST_CLEAR) && !sweep_done;
    hist_clear  = run_ok && (state_reg == ST_CLEAR) && sweep_done;
    strobe_adv  = run_ok && SAMPLE_STB &&
                  ((state_reg == ST_PRIME) || (state_reg == ST_RUN));
    fill_inc    = (state_reg == ST_PRIME) && !fill_hit;
  end

  trap_dly_ptr #(
    .ADDR_W (ADDR_W)
  ) u_ptr (
    .clk         (SYS_CLK),
    .srst        (RESET),
    .sweep_start (sweep_start),
    .sweep_step  (sweep_step),
    .hist_clear  (hist_clear),
    .strobe_adv  (strobe_adv),
    .fill_inc    (fill_inc),
    .active_dly  (active_dly_reg),
    .wp          (wp),
    .rd_addr     (rd_addr),
    .sweep_addr  (sweep_addr),
    .sweep_done  (sweep_done),
    .fill_hit    (fill_hit)
  );

  // Main FSM with registered outputs; DLY_VALID lags the RAM strobe by
  // one cycle so it lines up with the RAM's synchronous read data.
  always_ff @(posedge SYS_CLK) begin
    if (RESET) begin
      state_reg       <= ST_IDLE;
      active_dly_reg  <= ADDR_W'(DEFAULT_DLY);
      pending_dly_reg <= ADDR_W'(DEFAULT_DLY);
      ram_we_reg      <= 1'b0;
      ram_wzero_reg   <= 1'b0;
      ram_waddr_reg   <= '0;
      ram_raddr_reg   <= '0;
      valid_pend_reg  <= 1'b0;
      dly_valid_reg   <= 1'b0;
      busy_reg        <= 1'b0;
      drop_reg        <= 1'b0;
      cfg_err_reg     <= 1'b0;
    end else begin
      ram_we_reg     <= 1'b0;
      ram_wzero_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      drop_reg       <= 1'b0;
      // An accepted strobe always completes its DLY_VALID, even if the
      // block is disabled in between.
      dly_valid_reg  <= valid_pend_reg;
      valid_pend_reg <= 1'b0;
      cfg_err_reg    <= CFG_WE && (CFG_DLY == '0);

      if (cfg_ok) begin
        pending_dly_reg <= CFG_DLY;
      end

      if (!ENABLE) begin
        state_reg <= ST_IDLE;
        drop_reg  <= SAMPLE_STB;
      end else if (cfg_ok || (state_reg == ST_IDLE)) begin
        // (Re)start the clear sweep at address 0.
        state_reg     <= ST_CLEAR;
        busy_reg      <= 1'b1;
        ram_we_reg    <= 1'b1;
        ram_wzero_reg <= 1'b1;
        ram_waddr_reg <= '0;
        drop_reg      <= SAMPLE_STB;
      end else begin
        case (state_reg)
          ST_CLEAR: begin
            drop_reg <= SAMPLE_STB;
            if (sweep_done) begin
              state_reg      <= ST_PRIME;
              active_dly_reg <= pending_dly_reg;
            end else begin
              busy_reg      <= 1'b1;
              ram_we_reg    <= 1'b1;
              ram_wzero_reg <= 1'b1;
              ram_waddr_reg <= sweep_addr;
            end
          end
          ST_PRIME, ST_RUN: begin
            if (SAMPLE_STB) begin
              ram_we_reg    <= 1'b1;
              ram_waddr_reg <= wp;
              ram_raddr_reg <= rd_addr;
              if ((state_reg == ST_RUN) || fill_hit) begin
                valid_pend_reg <= 1'b1;
                state_reg      <= ST_RUN;
              end
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign ram.ram_we    = ram_we_reg;
  assign ram.ram_wzero = ram_wzero_reg;
  assign ram.ram_waddr = ram_waddr_reg;
  assign ram.ram_raddr = ram_raddr_reg;
  assign ram.dly_valid = dly_valid_reg;
  assign BUSY          = busy_reg;
  assign DROP          = drop_reg;
  assign CFG_ERR       = cfg_err_reg;
  assign STATE         = state_reg;
  assign ACTIVE_DLY    = active_dly_reg;

endmodule

// File: tb/tb_trap_dly_sched.sv
// Directed testbench for trap_dly_sched with a behavioural 1-cycle-read RAM
// so delayed data can be compared against the sample sequence.
module tb_trap_dly_sched;

  localparam int AW    = 9;
  localparam int DEPTH = 512;

  logic          SYS_CLK = 1'b0;
  logic          RESET, ENABLE, CFG_WE, SAMPLE_STB;
  logic [AW-1:0] CFG_DLY;
  logic          BUSY, DROP, CFG_ERR;
  logic [1:0]    STATE;
  logic [AW-1:0] ACTIVE_DLY;

  logic [15:0] sample_in, wdata_d, rdata;
  logic [15:0] mem [0:DEPTH-1];

  int tests = 0;
  int fails = 0;

  always #5 SYS_CLK = ~SYS_CLK;

  trap_dly_sched_if #(.ADDR_W(AW)) ram_if ();

  trap_dly_sched #(.ADDR_W(AW), .DEFAULT_DLY(372)) dut (
    .SYS_CLK    (SYS_CLK),
    .RESET      (RESET),
    .ENABLE     (ENABLE),
    .CFG_WE     (CFG_WE),
    .CFG_DLY    (CFG_DLY),
    .SAMPLE_STB (SAMPLE_STB),
    .ram        (ram_if),
    .BUSY       (BUSY),
    .DROP       (DROP),
    .CFG_ERR    (CFG_ERR),
    .STATE      (STATE),
    .ACTIVE_DLY (ACTIVE_DLY)
  );

  // External RAM: sample data is registered to line up with RAM_WE.
  always @(posedge SYS_CLK) begin
    wdata_d <= sample_in;
    if (ram_if.ram_we) mem[ram_if.ram_waddr] <= ram_if.ram_wzero ? 16'd0 : wdata_d;
    rdata <= mem[ram_if.ram_raddr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (tests=%0d)", tests);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic wait_prime;
    int i;
    for (i = 0; i < 700; i++) begin
      tick();
      if (STATE == 2'd2) break;
    end
    tests++;
    if (STATE !== 2'd2) begin
      fails++;
      $display("FAIL prime_timeout: STATE=%0d required 2", STATE);
    end
  endtask

  // Continuous strobes from a fresh PRIME (wp=0); sample n carries value n.
  task automatic run_strobes(input int k, input int count);
    logic [AW-1:0] exp_w, exp_r;
    logic [1:0]    exp_st;
    logic          exp_v;
    int            m;
    for (int n = 1; n <= count; n++) begin
      SAMPLE_STB = 1'b1;
      sample_in  = 16'(n);
      tick();
      exp_w  = AW'(n - 1);
      exp_r  = AW'(n - 1 - k);
      exp_st = (n >= k + 1) ? 2'd3 : 2'd2;
      tests++;
      if (ram_if.ram_we !== 1'b1 || ram_if.ram_wzero !== 1'b0 || ram_if.ram_waddr !== exp_w) begin
        fails++;
        $display("FAIL strobe_write n=%0d: we=%b wz=%b waddr=%0d required 1/0/%0d",
                 n, ram_if.ram_we, ram_if.ram_wzero, ram_if.ram_waddr, exp_w);
      end
      tests++;
      if (ram_if.ram_raddr !== exp_r) begin
        fails++;
        $display("FAIL strobe_raddr n=%0d: raddr=%0d required %0d", n, ram_if.ram_raddr, exp_r);
      end
      tests++;
      if (STATE !== exp_st) begin
        fails++;
        $display("FAIL strobe_state n=%0d: STATE=%0d required %0d", n, STATE, exp_st);
      end
      if (n >= 2) begin
        m     = n - 1;
        exp_v = (m >= k + 1);
        tests++;
        if (ram_if.dly_valid !== exp_v) begin
          fails++;
          $display("FAIL dly_valid m=%0d: got %b required %b", m, ram_if.dly_valid, exp_v);
        end
        tests++;
        if (rdata !== (exp_v ? 16'(m - k) : 16'd0)) begin
          fails++;
          $display("FAIL dly_data m=%0d: got %0d required %0d", m, rdata, exp_v ? (m - k) : 0);
        end
      end
    end
    SAMPLE_STB = 1'b0;
    tick();
    tests++;
    if (ram_if.ram_we !== 1'b0 || ram_if.dly_valid !== (count >= k + 1)) begin
      fails++;
      $display("FAIL strobe_tail: we=%b dly_valid=%b required 0/%b",
               ram_if.ram_we, ram_if.dly_valid, (count >= k + 1));
    end
    tick();
    tests++;
    if (ram_if.dly_valid !== 1'b0) begin
      fails++;
      $display("FAIL strobe_idle_valid: dly_valid=%b required 0", ram_if.dly_valid);
    end
    $display("[TB] strobes k=%0d count=%0d done", k, count);
  endtask

  task automatic test_reset;
    RESET = 1'b1; ENABLE = 1'b0; CFG_WE = 1'b0; CFG_DLY = '0;
    SAMPLE_STB = 1'b0; sample_in = '0;
    tick();
    tick();
    tests++;
    if (STATE !== 2'd0 || ACTIVE_DLY !== 9'd372) begin
      fails++;
      $display("FAIL reset_state: STATE=%0d ACTIVE_DLY=%0d required 0/372", STATE, ACTIVE_DLY);
    end
    tests++;
    if ({ram_if.ram_we, ram_if.ram_wzero, ram_if.dly_valid, BUSY, DROP, CFG_ERR} !== 6'b0) begin
      fails++;
      $display("FAIL reset_flags: we=%b wz=%b dv=%b busy=%b drop=%b err=%b required all 0",
               ram_if.ram_we, ram_if.ram_wzero, ram_if.dly_valid, BUSY, DROP, CFG_ERR);
    end
    tests++;
    if (ram_if.ram_waddr !== 9'd0 || ram_if.ram_raddr !== 9'd0) begin
      fails++;
      $display("FAIL reset_addr: waddr=%0d raddr=%0d required 0/0", ram_if.ram_waddr, ram_if.ram_raddr);
    end
    RESET = 1'b0;
    $display("[TB] reset checked");
  endtask

  task automatic test_clear_sweep;
    ENABLE = 1'b1;
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      tests++;
      if (BUSY !== 1'b1 || ram_if.ram_we !== 1'b1 || ram_if.ram_wzero !== 1'b1 ||
          ram_if.ram_waddr !== AW'(i) || STATE !== 2'd1) begin
        fails++;
        $display("FAIL clear_sweep i=%0d: busy=%b we=%b wz=%b waddr=%0d st=%0d required 1/1/1/%0d/1",
                 i, BUSY, ram_if.ram_we, ram_if.ram_wzero, ram_if.ram_waddr, STATE, i);
      end
      tick();
    end
    tests++;
    if (STATE !== 2'd2 || BUSY !== 1'b0 || ram_if.ram_we !== 1'b0 || ACTIVE_DLY !== 9'd372) begin
      fails++;
      $display("FAIL clear_end: st=%0d busy=%b we=%b dly=%0d required 2/0/0/372",
               STATE, BUSY, ram_if.ram_we, ACTIVE_DLY);
    end
    $display("[TB] clear sweep checked");
  endtask

  task automatic test_prime_k372;
    run_strobes(372, 380);
  endtask

  task automatic test_cfg_err;
    CFG_WE = 1'b1; CFG_DLY = '0;
    tick();
    CFG_WE = 1'b0;
    tests++;
    if (CFG_ERR !== 1'b1 || STATE !== 2'd3 || ACTIVE_DLY !== 9'd372) begin
      fails++;
      $display("FAIL cfg_err_pulse: err=%b st=%0d dly=%0d required 1/3/372", CFG_ERR, STATE, ACTIVE_DLY);
    end
    tick();
    tests++;
    if (CFG_ERR !== 1'b0 || STATE !== 2'd3) begin
      fails++;
      $display("FAIL cfg_err_clear: err=%b st=%0d required 0/3", CFG_ERR, STATE);
    end
    $display("[TB] cfg error checked");
  endtask

  task automatic test_wrap_k5;
    CFG_WE = 1'b1; CFG_DLY = 9'd5;
    tick();
    CFG_WE = 1'b0;
    tests++;
    if (STATE !== 2'd1 || BUSY !== 1'b1 || ram_if.ram_waddr !== 9'd0) begin
      fails++;
      $display("FAIL cfg_to_clear: st=%0d busy=%b waddr=%0d required 1/1/0", STATE, BUSY, ram_if.ram_waddr);
    end
    wait_prime();
    tests++;
    if (ACTIVE_DLY !== 9'd5) begin
      fails++;
      $display("FAIL wrap_dly: ACTIVE_DLY=%0d required 5", ACTIVE_DLY);
    end
    run_strobes(5, 600);
  endtask

  task automatic test_cfg_in_clear;
    ENABLE = 1'b0;
    tick();
    tests++;
    if (STATE !== 2'd0 || BUSY !== 1'b0) begin
      fails++;
      $display("FAIL disable_idle: st=%0d busy=%b required 0/0", STATE, BUSY);
    end
    ENABLE = 1'b1;
    tick();
    for (int i = 0; i < 200; i++) tick();
    tests++;
    if (ram_if.ram_waddr !== 9'd200 || STATE !== 2'd1) begin
      fails++;
      $display("FAIL sweep_200: waddr=%0d st=%0d required 200/1", ram_if.ram_waddr, STATE);
    end
    CFG_WE = 1'b1; CFG_DLY = 9'd10; SAMPLE_STB = 1'b1;
    tick();
    CFG_WE = 1'b0; SAMPLE_STB = 1'b0;
    tests++;
    if (ram_if.ram_waddr !== 9'd0 || BUSY !== 1'b1 || DROP !== 1'b1 || STATE !== 2'd1) begin
      fails++;
      $display("FAIL sweep_restart: waddr=%0d busy=%b drop=%b st=%0d required 0/1/1/1",
               ram_if.ram_waddr, BUSY, DROP, STATE);
    end
    tick();
    tests++;
    if (DROP !== 1'b0 || ram_if.ram_waddr !== 9'd1) begin
      fails++;
      $display("FAIL sweep_after_restart: drop=%b waddr=%0d required 0/1", DROP, ram_if.ram_waddr);
    end
    wait_prime();
    tests++;
    if (ACTIVE_DLY !== 9'd10) begin
      fails++;
      $display("FAIL clear_new_dly: ACTIVE_DLY=%0d required 10", ACTIVE_DLY);
    end
    $display("[TB] cfg during clear checked");
  endtask

  task automatic test_reset_mid_run;
    run_strobes(10, 15);
    SAMPLE_STB = 1'b1; sample_in = 16'd99;
    tick();
    tests++;
    if (STATE !== 2'd3) begin
      fails++;
      $display("FAIL pre_reset_run: STATE=%0d required 3", STATE);
    end
    RESET = 1'b1; ENABLE = 1'b0;
    tick();
    RESET = 1'b0;
    tests++;
    if (STATE !== 2'd0 || {ram_if.ram_we, ram_if.ram_wzero, ram_if.dly_valid, BUSY, DROP, CFG_ERR} !== 6'b0 ||
        ram_if.ram_waddr !== 9'd0 || ram_if.ram_raddr !== 9'd0 || ACTIVE_DLY !== 9'd372) begin
      fails++;
      $display("FAIL reset_mid_run: st=%0d we=%b dv=%b busy=%b drop=%b waddr=%0d raddr=%0d dly=%0d",
               STATE, ram_if.ram_we, ram_if.dly_valid, BUSY, DROP, ram_if.ram_waddr,
               ram_if.ram_raddr, ACTIVE_DLY);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (ram_if.ram_we !== 1'b0 || STATE !== 2'd0 || DROP !== 1'b1) begin
        fails++;
        $display("FAIL idle_strobe i=%0d: we=%b st=%0d drop=%b required 0/0/1",
                 i, ram_if.ram_we, STATE, DROP);
      end
    end
    SAMPLE_STB = 1'b0; ENABLE = 1'b1;
    tick();
    tests++;
    if (STATE !== 2'd1 || ram_if.ram_wzero !== 1'b1) begin
      fails++;
      $display("FAIL reenable_clear: st=%0d wz=%b required 1/1", STATE, ram_if.ram_wzero);
    end
    wait_prime();
    $display("[TB] reset mid-run checked");
  endtask

  task automatic test_cfg_while_disabled;
    ENABLE = 1'b0; CFG_WE = 1'b1; CFG_DLY = 9'd7;
    tick();
    CFG_WE = 1'b0;
    tests++;
    if (STATE !== 2'd0 || BUSY !== 1'b0 || ACTIVE_DLY !== 9'd372) begin
      fails++;
      $display("FAIL cfg_disabled: st=%0d busy=%b dly=%0d required 0/0/372", STATE, BUSY, ACTIVE_DLY);
    end
    ENABLE = 1'b1;
    tick();
    wait_prime();
    tests++;
    if (ACTIVE_DLY !== 9'd7) begin
      fails++;
      $display("FAIL cfg_disabled_apply: ACTIVE_DLY=%0d required 7", ACTIVE_DLY);
    end
    $display("[TB] cfg while disabled checked");
  endtask

  initial begin
    test_reset();
    test_clear_sweep();
    test_prime_k372();
    test_cfg_err();
    test_wrap_k5();
    test_cfg_in_clear();
    test_reset_mid_run();
    test_cfg_while_disabled();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
